// File: rtl/wm_replay_pkg.sv
// rtl/wm_replay_pkg.sv - shared FSM state type and default geometry for the watermark replay block
package wm_replay_pkg;

  localparam int unsigned WM_DATA_WIDTH_DEF = 512;
  localparam int unsigned WM_DEPTH_DEF      = 512;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LOAD   = 2'd1,
    ST_REPLAY = 2'd2
  } wm_state_e;

endpackage

// File: rtl/wm_replay_ram.sv
// rtl/wm_replay_ram.sv - simple dual-port watermark store, one write port and one registered read port
module wm_replay_ram
  import wm_replay_pkg::*;
#(
  parameter int unsigned C_DATA_WIDTH = WM_DATA_WIDTH_DEF,
  parameter int unsigned C_DEPTH      = WM_DEPTH_DEF,
  localparam int unsigned AW          = $clog2(C_DEPTH)
) (
  input  logic                    clk,
  input  logic                    wr_en,
  input  logic [AW-1:0]           wr_addr,
  input  logic [C_DATA_WIDTH-1:0] wr_data,
  input  logic                    rd_en,
  input  logic [AW-1:0]           rd_addr,
  output logic [C_DATA_WIDTH-1:0] rd_data
);

  logic [C_DATA_WIDTH-1:0] mem_q [C_DEPTH];
  logic [C_DATA_WIDTH-1:0] rd_data_q;

  // Contents are deliberately left unreset so the array maps onto block RAM.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wr_addr] <= wr_data;
    end
    if (rd_en) begin
      rd_data_q <= mem_q[rd_addr];
    end
  end

  assign rd_data = rd_data_q;

endmodule

// File: rtl/wm_stream_replay.sv
// rtl/wm_stream_replay.sv - loads a watermark burst once and replays it endlessly on an output stream
// Optional pass counter port o_pass_cnt is built when WM_REPLAY_PASS_CNT_EN is defined.
module wm_stream_replay
  import wm_replay_pkg::*;
#(
  parameter int unsigned C_DATA_WIDTH = WM_DATA_WIDTH_DEF,
  parameter int unsigned C_DEPTH      = WM_DEPTH_DEF
) (
  input  logic                    kernel_clk,
  input  logic                    kernel_rst,
  input  logic                    i_start,
  input  logic                    i_done,
  input  logic [C_DATA_WIDTH-1:0] s_axis_wm_tdata,
  input  logic                    s_axis_wm_tvalid,
  output logic                    s_axis_wm_tready,
  input  logic                    s_axis_wm_tlast,
  output logic [C_DATA_WIDTH-1:0] m_axis_wm_tdata,
  output logic                    m_axis_wm_tvalid,
  input  logic                    m_axis_wm_tready,
  output logic                    m_axis_wm_tlast,
  output logic                    o_loaded,
  output logic                    o_ovf
`ifdef WM_REPLAY_PASS_CNT_EN
  ,
  output logic [15:0]             o_pass_cnt
`endif
);

  localparam int unsigned AW = $clog2(C_DEPTH);
  localparam int unsigned LW = AW + 1;
  localparam logic [AW-1:0] PTR_MAX   = AW'(C_DEPTH - 1);
  localparam logic [LW-1:0] LEN_ONE   = LW'(1);
  localparam logic [LW-1:0] DEPTH_LEN = LW'(C_DEPTH);

  wm_state_e state_q, state_d;

  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [LW-1:0] len_q, len_d;
  logic          full_q, full_d;
  logic          loaded_q, loaded_d;
  logic          ovf_q, ovf_d;

  // pend_q marks a RAM read whose data is on ram_rdata this cycle.
  logic          pend_q, pend_d;
  logic          pend_last_q, pend_last_d;

  // Two-entry output stage; slot 0 drives the master port directly.
  logic                    v0_q, v0_d, v1_q, v1_d;
  logic                    l0_q, l0_d, l1_q, l1_d;
  logic [C_DATA_WIDTH-1:0] d0_q, d0_d, d1_q, d1_d;

  logic                    ram_we;
  logic                    ram_re;
  logic [C_DATA_WIDTH-1:0] ram_rdata;
  logic                    s_hs;
  logic                    pop;
  logic [1:0]              occ;

`ifdef WM_REPLAY_PASS_CNT_EN
  logic [15:0] pass_cnt_q, pass_cnt_d;
`endif

  wm_replay_ram #(
    .C_DATA_WIDTH (C_DATA_WIDTH),
    .C_DEPTH      (C_DEPTH)
  ) u_ram (
    .clk     (kernel_clk),
    .wr_en   (ram_we),
    .wr_addr (wr_ptr_q),
    .wr_data (s_axis_wm_tdata),
    .rd_en   (ram_re),
    .rd_addr (rd_ptr_q),
    .rd_data (ram_rdata)
  );

  always_comb begin
    state_d     = state_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    len_d       = len_q;
    full_d      = full_q;
    loaded_d    = loaded_q;
    ovf_d       = ovf_q;
    pend_d      = 1'b0;
    pend_last_d = pend_last_q;
    v0_d        = v0_q;
    v1_d        = v1_q;
    l0_d        = l0_q;
    l1_d        = l1_q;
    d0_d        = d0_q;
    d1_d        = d1_q;
    ram_we      = 1'b0;
    ram_re      = 1'b0;
`ifdef WM_REPLAY_PASS_CNT_EN
    pass_cnt_d  = pass_cnt_q;
`endif

    s_hs = s_axis_wm_tvalid && (state_q == ST_LOAD);
    pop  = v0_q && m_axis_wm_tready;
    // Words already committed to the output stage after this cycle's pop.
    occ  = {1'b0, v0_q} + {1'b0, v1_q} + {1'b0, pend_q} - {1'b0, pop};

    if (pop) begin
      v0_d = v1_q;
      l0_d = l1_q;
      d0_d = d1_q;
      v1_d = 1'b0;
    end
    if (pend_q) begin
      if (!v0_d) begin
        v0_d = 1'b1;
        l0_d = pend_last_q;
        d0_d = ram_rdata;
      end else begin
        v1_d = 1'b1;
        l1_d = pend_last_q;
        d1_d = ram_rdata;
      end
    end

`ifdef WM_REPLAY_PASS_CNT_EN
    if (pop && l0_q) begin
      pass_cnt_d = pass_cnt_q + 16'd1;
    end
`endif

    unique case (state_q)
      ST_LOAD: begin
        if (s_hs) begin
          if (!full_q) begin
            ram_we   = 1'b1;
            wr_ptr_d = wr_ptr_q + 1'b1;
            if (wr_ptr_q == PTR_MAX) begin
              full_d = 1'b1;
            end
          end else begin
            ovf_d = 1'b1;
          end
          if (s_axis_wm_tlast) begin
            len_d    = full_q ? DEPTH_LEN : ({1'b0, wr_ptr_q} + LEN_ONE);
            loaded_d = 1'b1;
            state_d  = ST_REPLAY;
          end
        end
      end
      ST_REPLAY: begin
        if (i_done) begin
          state_d = ST_IDLE;
          v0_d    = 1'b0;
          v1_d    = 1'b0;
        end else if (occ < 2'd2) begin
          ram_re      = 1'b1;
          pend_d      = 1'b1;
          pend_last_d = ({1'b0, rd_ptr_q} == (len_q - LEN_ONE));
          rd_ptr_d    = pend_last_d ? '0 : rd_ptr_q + 1'b1;
        end
      end
      default: begin
      end
    endcase

    if (i_start) begin
      state_d  = ST_LOAD;
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      full_d   = 1'b0;
      loaded_d = 1'b0;
      ovf_d    = 1'b0;
      pend_d   = 1'b0;
      v0_d     = 1'b0;
      v1_d     = 1'b0;
      ram_we   = 1'b0;
      ram_re   = 1'b0;
`ifdef WM_REPLAY_PASS_CNT_EN
      pass_cnt_d = 16'd0;
`endif
    end
  end

  always_ff @(posedge kernel_clk) begin
    if (kernel_rst) begin
      state_q     <= ST_IDLE;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      len_q       <= '0;
      full_q      <= 1'b0;
      loaded_q    <= 1'b0;
      ovf_q       <= 1'b0;
      pend_q      <= 1'b0;
      pend_last_q <= 1'b0;
      v0_q        <= 1'b0;
      v1_q        <= 1'b0;
      l0_q        <= 1'b0;
      l1_q        <= 1'b0;
      d0_q        <= '0;
      d1_q        <= '0;
`ifdef WM_REPLAY_PASS_CNT_EN
      pass_cnt_q  <= 16'd0;
`endif
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      len_q       <= len_d;
      full_q      <= full_d;
      loaded_q    <= loaded_d;
      ovf_q       <= ovf_d;
      pend_q      <= pend_d;
      pend_last_q <= pend_last_d;
      v0_q        <= v0_d;
      v1_q        <= v1_d;
      l0_q        <= l0_d;
      l1_q        <= l1_d;
      d0_q        <= d0_d;
      d1_q        <= d1_d;
`ifdef WM_REPLAY_PASS_CNT_EN
      pass_cnt_q  <= pass_cnt_d;
`endif
    end
  end

  assign s_axis_wm_tready = (state_q == ST_LOAD);
  assign m_axis_wm_tdata  = d0_q;
  assign m_axis_wm_tvalid = v0_q;
  assign m_axis_wm_tlast  = l0_q;
  assign o_loaded         = loaded_q;
  assign o_ovf            = ovf_q;
`ifdef WM_REPLAY_PASS_CNT_EN
  assign o_pass_cnt       = pass_cnt_q;
`endif

endmodule

// File: tb/tb_wm_stream_replay.sv
// tb/tb_wm_stream_replay.sv - randomized replay bench against a periodic-sequence reference model
module tb_wm_stream_replay;

  localparam int DW    = 32;
  localparam int DEPTH = 8;

  logic          kernel_clk = 1'b0;
  logic          kernel_rst = 1'b1;
  logic          i_start    = 1'b0;
  logic          i_done     = 1'b0;
  logic [DW-1:0] s_tdata    = '0;
  logic          s_tvalid   = 1'b0;
  logic          s_tready;
  logic          s_tlast    = 1'b0;
  logic [DW-1:0] m_tdata;
  logic          m_tvalid;
  logic          m_tready   = 1'b0;
  logic          m_tlast;
  logic          o_loaded;
  logic          o_ovf;
`ifdef WM_REPLAY_PASS_CNT_EN
  logic [15:0]   o_pass_cnt;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  logic [DW-1:0] load_q[$];
  logic [DW-1:0] exp_q[$];
  bit            exp_ovf;
  int            idx;
  int            exp_pass;

  always #5 kernel_clk = ~kernel_clk;

  wm_stream_replay #(
    .C_DATA_WIDTH (DW),
    .C_DEPTH      (DEPTH)
  ) dut (
    .kernel_clk       (kernel_clk),
    .kernel_rst       (kernel_rst),
    .i_start          (i_start),
    .i_done           (i_done),
    .s_axis_wm_tdata  (s_tdata),
    .s_axis_wm_tvalid (s_tvalid),
    .s_axis_wm_tready (s_tready),
    .s_axis_wm_tlast  (s_tlast),
    .m_axis_wm_tdata  (m_tdata),
    .m_axis_wm_tvalid (m_tvalid),
    .m_axis_wm_tready (m_tready),
    .m_axis_wm_tlast  (m_tlast),
    .o_loaded         (o_loaded),
    .o_ovf            (o_ovf)
`ifdef WM_REPLAY_PASS_CNT_EN
    ,
    .o_pass_cnt       (o_pass_cnt)
`endif
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_tvalid"}, m_tvalid, 0);
    check({tag, "_tdata"}, m_tdata, 0);
    check({tag, "_tlast"}, m_tlast, 0);
    check({tag, "_sready"}, s_tready, 0);
    check({tag, "_loaded"}, o_loaded, 0);
    check({tag, "_ovf"}, o_ovf, 0);
`ifdef WM_REPLAY_PASS_CNT_EN
    check({tag, "_pass_cnt"}, o_pass_cnt, 0);
`endif
  endtask

  // Build the expected stored image: everything beyond DEPTH words is dropped.
  task automatic make_words(input int n, input bit fixed);
    load_q.delete();
    exp_q.delete();
    for (int i = 0; i < n; i++) begin
      load_q.push_back(fixed ? DW'(32'hA + i) : DW'($urandom));
    end
    for (int i = 0; i < n && i < DEPTH; i++) exp_q.push_back(load_q[i]);
    exp_ovf = (n > DEPTH);
  endtask

  task automatic do_load(input bit gaps);
    int i;
    int budget;
    @(negedge kernel_clk);
    i_start  = 1'b1;
    s_tvalid = 1'b0;
    @(negedge kernel_clk);
    i_start = 1'b0;
    check("start_loaded", o_loaded, 0);
    check("start_ovf", o_ovf, 0);
    check("start_tvalid", m_tvalid, 0);
    check("start_sready", s_tready, 1);
    idx      = 0;
    exp_pass = 0;
    i        = 0;
    budget   = 0;
    while (i < load_q.size() && budget < 200) begin
      if (gaps && $urandom_range(0, 3) == 0) begin
        s_tvalid = 1'b0;
      end else begin
        s_tvalid = 1'b1;
        s_tdata  = load_q[i];
        s_tlast  = (i == load_q.size() - 1);
      end
      if (s_tvalid && s_tready) i++;
      budget++;
      if (i < load_q.size()) @(negedge kernel_clk);
    end
    check("load_words_accepted", i, load_q.size());
  endtask

  task automatic run_replay(input int ncyc, input int pct, input bit chk_lat);
    int first;
    int len;
    int pos;
    bit prev_v;
    bit prev_r;
    bit prev_l;
    logic [DW-1:0] prev_d;
    first  = 0;
    prev_v = 1'b0;
    prev_r = 1'b0;
    prev_l = 1'b0;
    prev_d = '0;
    len    = exp_q.size();
    for (int c = 1; c <= ncyc; c++) begin
      @(negedge kernel_clk);
      s_tvalid = 1'b0;
      s_tlast  = 1'b0;
      if (c == 1 && chk_lat) begin
        check("replay_loaded", o_loaded, 1);
        check("replay_ovf", o_ovf, exp_ovf);
        check("replay_sready", s_tready, 0);
      end
      if (prev_v && !prev_r) begin
        check("stall_tvalid", m_tvalid, 1);
        check("stall_tdata", m_tdata, prev_d);
        check("stall_tlast", m_tlast, prev_l);
      end
      if (m_tvalid && first == 0) first = c;
      m_tready = (pct >= 100) ? 1'b1 : ($urandom_range(0, 99) < pct);
      if (m_tvalid && m_tready) begin
        pos = idx % len;
        check("replay_tdata", m_tdata, exp_q[pos]);
        check("replay_tlast", m_tlast, (pos == len - 1));
        if (pos == len - 1) exp_pass++;
        idx++;
      end
      prev_v = m_tvalid;
      prev_r = m_tready;
      prev_d = m_tdata;
      prev_l = m_tlast;
    end
    if (chk_lat) check("first_valid_cycle", first, 3);
    @(negedge kernel_clk);
    m_tready = 1'b0;
`ifdef WM_REPLAY_PASS_CNT_EN
    check("pass_cnt", o_pass_cnt, exp_pass);
`endif
  endtask

  initial begin
    repeat (3) @(negedge kernel_clk);
    check_idle_outputs("reset");
    kernel_rst = 1'b0;

    // Four fixed words at full rate: ten words in ten ready cycles.
    make_words(4, 1'b1);
    do_load(1'b0);
    run_replay(12, 100, 1'b1);
    check("full_rate_count", idx, 10);

    // Three random words, 50% backpressure.
    make_words(3, 1'b0);
    do_load(1'b1);
    run_replay(300, 50, 1'b1);

    // Overflow: ten words into an eight-deep store.
    make_words(10, 1'b0);
    do_load(1'b1);
    run_replay(60, 70, 1'b1);

    // Single-word watermark.
    load_q.delete();
    exp_q.delete();
    load_q.push_back(DW'(32'h5));
    exp_q.push_back(DW'(32'h5));
    exp_ovf = 1'b0;
    do_load(1'b0);
    run_replay(30, 60, 1'b1);

    // i_done mid-pass, then a fresh two-word load.
    make_words(6, 1'b0);
    do_load(1'b0);
    run_replay(7, 100, 1'b1);
    @(negedge kernel_clk);
    i_done   = 1'b1;
    m_tready = 1'b1;
    @(negedge kernel_clk);
    i_done   = 1'b0;
    m_tready = 1'b0;
    check("done_tvalid", m_tvalid, 0);
    check("done_loaded_kept", o_loaded, 1);
    check("done_sready", s_tready, 0);
    @(negedge kernel_clk);
    check("done_tvalid_hold", m_tvalid, 0);
    make_words(2, 1'b0);
    do_load(1'b1);
    run_replay(20, 80, 1'b1);

    // Reset during replay.
    make_words(5, 1'b0);
    do_load(1'b0);
    run_replay(10, 100, 1'b1);
    @(negedge kernel_clk);
    kernel_rst = 1'b1;
    m_tready   = 1'b1;
    @(negedge kernel_clk);
    kernel_rst = 1'b0;
    m_tready   = 1'b0;
    check_idle_outputs("midrst");

    // Coincident i_start and i_done: start wins.
    make_words(4, 1'b0);
    do_load(1'b0);
    run_replay(8, 100, 1'b1);
    @(negedge kernel_clk);
    i_start = 1'b1;
    i_done  = 1'b1;
    @(negedge kernel_clk);
    i_start = 1'b0;
    i_done  = 1'b0;
    check("start_done_sready", s_tready, 1);
    check("start_done_tvalid", m_tvalid, 0);
    check("start_done_loaded", o_loaded, 0);
    make_words(3, 1'b0);
    do_load(1'b1);
    run_replay(40, 50, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
